// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter, the SPI slave FSM and the data memory.
// No logic: types and constants only.
// Build option DM_ARB_SPI_PRIORITY_EN (used in dm_arbiter) selects fixed SPI priority.
package dm_arb_pkg;

    // Default data-memory geometry: SPI address byte minus the rw bit, byte-wide words
    localparam int DM_ADDR_WIDTH = 7;
    localparam int DM_DATA_WIDTH = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_arb_state_t;

    // Requester port indices
    localparam logic PORT_SPI  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way grant picker: round-robin against the last-grant pointer, or fixed SPI priority.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the grant is only a suggestion the sequencer takes when it is idle.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic [1:0] i_elig,
    input  logic       i_ptr,
    input  logic       i_prio,
    output logic       o_gnt_idx,
    output logic       o_gnt_vld
);

    // Choose one eligible port; on a tie favour the port not granted last, unless SPI priority is on
    always_comb begin
        o_gnt_idx = PORT_SPI;
        o_gnt_vld = |i_elig;
        case (i_elig)
            2'b01:   o_gnt_idx = PORT_SPI;
            2'b10:   o_gnt_idx = PORT_HOST;
            2'b11:   o_gnt_idx = i_prio ? PORT_SPI : ~i_ptr;
            default: o_gnt_idx = PORT_SPI;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates SPI (port 0) and host (port 1) onto the data memory and runs a fixed IDLE/ACCESS/RESP access.
// Latency: req sampled at edge N -> ACCESS after N, RESP after N+1, ack pulse and rdata after N+2.
// Backpressure: req/ack handshake; a requester holds req until its one-cycle ack, the loser simply waits.
// Build option DM_ARB_SPI_PRIORITY_EN: port 0 always wins a tie (port 1 may starve).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic [DATA_WIDTH-1:0] dm_din,
    output logic                  dm_we,
    input  logic [DATA_WIDTH-1:0] dm_dout,
    output logic                  busy
);

`ifdef DM_ARB_SPI_PRIORITY_EN
    localparam logic PRIO_MODE = 1'b1;
`else
    localparam logic PRIO_MODE = 1'b0;
`endif

    dm_arb_state_t         r_state;
    logic                  r_ptr;
    logic                  r_gnt;
    logic                  r_wr;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_dm_we;
    logic [ADDR_WIDTH-1:0] r_dm_addr;
    logic [DATA_WIDTH-1:0] r_dm_din;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_busy;

    dm_arb_state_t         w_nxt_state;
    logic                  w_nxt_ptr;
    logic                  w_nxt_gnt;
    logic                  w_nxt_wr;
    logic                  w_nxt_ack0;
    logic                  w_nxt_ack1;
    logic                  w_nxt_dm_we;
    logic [ADDR_WIDTH-1:0] w_nxt_dm_addr;
    logic [DATA_WIDTH-1:0] w_nxt_dm_din;
    logic [DATA_WIDTH-1:0] w_nxt_rdata;
    logic                  w_nxt_busy;

    logic [1:0]            w_elig;
    logic                  w_gnt_idx;
    logic                  w_gnt_vld;

    // A port whose ack is high this cycle is finishing its handshake and must not be re-granted yet
    assign w_elig = {req1 & ~r_ack1, req0 & ~r_ack0};

    dm_arb_pick u_pick (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .i_prio    (PRIO_MODE),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // Next-state and next-output decode for the three-state access sequence
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ptr     = r_ptr;
        w_nxt_gnt     = r_gnt;
        w_nxt_wr      = r_wr;
        w_nxt_ack0    = 1'b0;
        w_nxt_ack1    = 1'b0;
        w_nxt_dm_we   = 1'b0;
        w_nxt_dm_addr = r_dm_addr;
        w_nxt_dm_din  = r_dm_din;
        w_nxt_rdata   = r_rdata;
        w_nxt_busy    = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_nxt_state = ST_ACCESS;
                    w_nxt_gnt   = w_gnt_idx;
                    w_nxt_busy  = 1'b1;
                    if (w_gnt_idx == PORT_HOST) begin
                        w_nxt_wr      = we1;
                        w_nxt_dm_we   = we1;
                        w_nxt_dm_addr = addr1;
                        w_nxt_dm_din  = wdata1;
                    end else begin
                        w_nxt_wr      = we0;
                        w_nxt_dm_we   = we0;
                        w_nxt_dm_addr = addr0;
                        w_nxt_dm_din  = wdata0;
                    end
                end
            end
            ST_ACCESS: begin
                // Write strobe drops here; memory read data becomes valid during RESP
                w_nxt_state = ST_RESP;
            end
            ST_RESP: begin
                if (!r_wr) begin
                    w_nxt_rdata = dm_dout;
                end
                if (r_gnt == PORT_HOST) begin
                    w_nxt_ack1 = 1'b1;
                end else begin
                    w_nxt_ack0 = 1'b1;
                end
                w_nxt_ptr   = r_gnt;
                w_nxt_busy  = 1'b0;
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight without an ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PORT_HOST;
            r_gnt     <= PORT_SPI;
            r_wr      <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_dm_we   <= 1'b0;
            r_dm_addr <= '0;
            r_dm_din  <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_ptr     <= w_nxt_ptr;
            r_gnt     <= w_nxt_gnt;
            r_wr      <= w_nxt_wr;
            r_ack0    <= w_nxt_ack0;
            r_ack1    <= w_nxt_ack1;
            r_dm_we   <= w_nxt_dm_we;
            r_dm_addr <= w_nxt_dm_addr;
            r_dm_din  <= w_nxt_dm_din;
            r_rdata   <= w_nxt_rdata;
            r_busy    <= w_nxt_busy;
        end
    end

    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign dm_we   = r_dm_we;
    assign dm_addr = r_dm_addr;
    assign dm_din  = r_dm_din;
    assign rdata   = r_rdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed requests push expected acks/writes, a monitor pops and compares.
// Latency: expected ack three cycles after the req edge for uncontended requests.
// Backpressure: requesters hold req until ack (bounded wait), then drop it.
module tb_dm_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, dm_we, busy;
    logic [7:0] rdata, dm_din, dm_dout;
    logic [6:0] dm_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         port;
        logic       we;
        logic [6:0] addr;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    logic [7:0]   mem [0:127];
    logic [127:0] mem_vld = '0;
    logic         prev_we = 1'b0;

    dm_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .ack0    (ack0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .ack1    (ack1),
        .rdata   (rdata),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_we   (dm_we),
        .dm_dout (dm_dout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory; unwritten words read as addr ^ 0x3C
    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr]     <= dm_din;
            mem_vld[dm_addr] <= 1'b1;
        end
        dm_dout <= mem_vld[dm_addr] ? mem[dm_addr] : ({1'b0, dm_addr} ^ 8'h3C);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void exp_ack(input int p, input logic w, input logic [6:0] a,
                                    input logic [7:0] rd, input int c);
        exp_t e;
        e.port = p; e.we = w; e.addr = a; e.rdata = rd; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_wr(input logic [6:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endfunction

    // Monitor: compares every ack and every write strobe against the scoreboard
    always @(negedge clk) begin
        if (ack0 | ack1) begin
            chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_port", {31'd0, ack1}, e.port);
                chk("ack_addr", {25'd0, dm_addr}, {25'd0, e.addr});
                if (!e.we) chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
                if (e.cyc >= 0) chk("ack_latency", cyc, e.cyc);
            end
        end
        if (dm_we === 1'b1) begin
            chk("we_one_cycle", {31'd0, prev_we}, 32'd0);
            if (wr_q.size() == 0) begin
                chk("unexpected_write", {31'd0, dm_we}, 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", {25'd0, dm_addr}, {25'd0, w.addr});
                chk("wr_data", {24'd0, dm_din}, {24'd0, w.data});
            end
        end
        prev_we <= (dm_we === 1'b1);
    end

    task automatic set_req(input int p, input logic r, input logic w,
                           input logic [6:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Requester: raise req, wait (bounded) for own ack, keep req for `hold` more cycles, drop
    task automatic do_req(input int p, input logic w, input logic [6:0] a,
                          input logic [7:0] d, input int hold);
        bit got = 0;
        set_req(p, 1'b1, w, a, d);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if ((p == 0) ? ack0 : ack1) got = 1;
        end
        chk($sformatf("ack_seen_p%0d", p), {31'd0, got}, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        set_req(p, 1'b0, 1'b0, 7'd0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 7'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 7'd0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
        chk("rst_dm_addr", {25'd0, dm_addr}, 32'd0);
        chk("rst_dm_din", {24'd0, dm_din}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Tie right after reset: port 0 first in both modes
        @(posedge clk); #1;
        exp_ack(0, 1'b0, 7'h20, 8'h1C, cyc + 3);
        exp_ack(1, 1'b0, 7'h33, 8'h0F, -1);
        fork
            do_req(0, 1'b0, 7'h20, 8'h00, 0);
            do_req(1, 1'b0, 7'h33, 8'h00, 0);
        join
        repeat (3) @(posedge clk);

        // Port 1 write 0x05 <= 0xA5
        #1;
        exp_wr(7'h05, 8'hA5);
        exp_ack(1, 1'b1, 7'h05, 8'h00, cyc + 3);
        do_req(1, 1'b1, 7'h05, 8'hA5, 0);
        repeat (3) @(posedge clk);

        // Port 0 reads it back; rdata must hold afterwards
        #1;
        exp_ack(0, 1'b0, 7'h05, 8'hA5, cyc + 3);
        do_req(0, 1'b0, 7'h05, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", {24'd0, rdata}, 32'hA5);

        // Second tie: last grant was port 0, so round-robin serves port 1 first
        @(posedge clk); #1;
`ifdef DM_ARB_SPI_PRIORITY_EN
        exp_ack(0, 1'b0, 7'h41, 8'h7D, cyc + 3);
        exp_ack(1, 1'b0, 7'h7F, 8'h43, -1);
`else
        exp_ack(1, 1'b0, 7'h7F, 8'h43, cyc + 3);
        exp_ack(0, 1'b0, 7'h41, 8'h7D, -1);
`endif
        fork
            do_req(0, 1'b0, 7'h41, 8'h00, 0);
            do_req(1, 1'b0, 7'h7F, 8'h00, 0);
        join
        repeat (3) @(posedge clk);

        // Port 0 holds req two cycles past ack: a second access at the same address
        #1;
        exp_ack(0, 1'b0, 7'h0A, 8'h36, cyc + 3);
        exp_ack(0, 1'b0, 7'h0A, 8'h36, -1);
        do_req(0, 1'b0, 7'h0A, 8'h00, 2);
        repeat (5) @(posedge clk);

        // Port 1 drops req during ACCESS: one ack, no further grant
        #1;
        exp_ack(1, 1'b0, 7'h12, 8'h2E, cyc + 3);
        set_req(1, 1'b1, 1'b0, 7'h12, 8'h00);
        @(posedge clk); #1;
        chk("busy_access", {31'd0, busy}, 32'd1);
        set_req(1, 1'b0, 1'b0, 7'd0, 8'd0);
        repeat (12) @(posedge clk);
        chk("drop_drained", exp_q.size(), 32'd0);

        // Reset during the ACCESS cycle of a write to 0x10
        #1;
        exp_wr(7'h10, 8'h5A);
        set_req(1, 1'b1, 1'b1, 7'h10, 8'h5A);
        @(posedge clk); #1;
        chk("abort_we_in_access", {31'd0, dm_we}, 32'd1);
        reset = 1'b1;
        set_req(1, 1'b0, 1'b0, 7'd0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_we", {31'd0, dm_we}, 32'd0);
        chk("abort_ack1", {31'd0, ack1}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        chk("abort_no_ack", exp_q.size(), 32'd0);

        // Tie after reset release: port 0 wins again
        @(posedge clk); #1;
        exp_ack(0, 1'b0, 7'h20, 8'h1C, cyc + 3);
        exp_ack(1, 1'b0, 7'h33, 8'h0F, -1);
        fork
            do_req(0, 1'b0, 7'h20, 8'h00, 0);
            do_req(1, 1'b0, 7'h33, 8'h00, 0);
        join

        repeat (10) @(posedge clk);
        #1;
        chk("ack_queue_empty", exp_q.size(), 32'd0);
        chk("wr_queue_empty", wr_q.size(), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
